// File: rtl/cv32e40p_voter_monitor.sv
// cv32e40p_voter_monitor
// Registered triple-modular-redundancy voter with per-replica fault tracking.
// Each valid cycle one triple is voted. Replicas that disagree are flagged and
// counted. After THRESH consecutive disagreements a replica is marked FAILED
// and excluded from later votes until clear_i or rst_i.
//
// Optional build macro:
//   VOTER_BITWISE_EN - with three active replicas, vote by per-bit majority
//                      instead of whole-word agreement.

module cv32e40p_voter_monitor #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   res1_i,
  input  logic [WIDTH-1:0]   res2_i,
  input  logic [WIDTH-1:0]   res3_i,
  input  logic               clear_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               valid_o,
  output logic [2:0]         mismatch_o,
  output logic               uncorr_o,
  output logic [2:0]         failed_o,
  output logic               fatal_o,
  output logic [3*CNT_W-1:0] err_cnt_o
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAILED  = 2'd2
  } rep_state_e;

  rep_state_e       state_q   [3];
  logic [CNT_W-1:0] run_cnt_q [3];
  logic [CNT_W-1:0] err_cnt_q [3];

  logic [WIDTH-1:0] res [3];
  logic [2:0]       active;

  // Vote outcome for the current cycle.
  logic [WIDTH-1:0] vote_res;
  logic [2:0]       vote_mis;   // replica disagreed with the vote
  logic [2:0]       vote_chk;   // replica's FSM is evaluated by this vote
  logic             vote_unc;

  // Saturating next values of the counters on a mismatch.
  logic [CNT_W-1:0] run_inc [3];
  logic [CNT_W-1:0] err_inc [3];

  assign res[0] = res1_i;
  assign res[1] = res2_i;
  assign res[2] = res3_i;

  // Active set, sticky-failure flags and the fatal summary.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      active[i]   = (state_q[i] != FAILED);
      failed_o[i] = (state_q[i] == FAILED);
    end
    fatal_o = (failed_o[0] & failed_o[1]) | (failed_o[0] & failed_o[2]) |
              (failed_o[1] & failed_o[2]);
  end

  // Pack the per-replica total counters onto the output bus.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      err_cnt_o[i*CNT_W +: CNT_W] = err_cnt_q[i];
    end
  end

  // Saturating increments for both counter kinds.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      run_inc[i] = (run_cnt_q[i] == '1) ? run_cnt_q[i] : run_cnt_q[i] + 1'b1;
      err_inc[i] = (err_cnt_q[i] == '1) ? err_cnt_q[i] : err_cnt_q[i] + 1'b1;
    end
  end

  // Vote over the replicas that were active before this edge.
  always_comb begin
    logic [1:0]       lo;
    logic [1:0]       hi;
    logic             two_act;
    logic [WIDTH-1:0] maj;
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch can be inferred.
    vote_res = res[0];
    vote_mis = '0;
    vote_chk = '0;
    vote_unc = 1'b0;
    lo       = 2'd0;
    hi       = 2'd0;
    two_act  = 1'b0;
    maj      = '0;

    unique case (active)
      3'b111: begin
`ifdef VOTER_BITWISE_EN
        maj      = (res[0] & res[1]) | (res[0] & res[2]) | (res[1] & res[2]);
        vote_res = maj;
        vote_chk = 3'b111;
        for (int i = 0; i < 3; i++) vote_mis[i] = (res[i] != maj);
`else
        if (res[0] == res[1] && res[1] == res[2]) begin
          vote_res = res[0];
          vote_chk = 3'b111;
        end else if (res[0] == res[1]) begin
          vote_res = res[0];
          vote_chk = 3'b111;
          vote_mis = 3'b100;
        end else if (res[0] == res[2]) begin
          vote_res = res[0];
          vote_chk = 3'b111;
          vote_mis = 3'b010;
        end else if (res[1] == res[2]) begin
          vote_res = res[1];
          vote_chk = 3'b111;
          vote_mis = 3'b001;
        end else begin
          // No pair agrees: nobody can be blamed, so FSMs are left alone.
          vote_res = res[1];
          vote_unc = 1'b1;
        end
`endif
      end
      3'b011: begin lo = 2'd0; hi = 2'd1; two_act = 1'b1; end
      3'b101: begin lo = 2'd0; hi = 2'd2; two_act = 1'b1; end
      3'b110: begin lo = 2'd1; hi = 2'd2; two_act = 1'b1; end
      3'b001: vote_res = res[0];
      3'b010: vote_res = res[1];
      3'b100: vote_res = res[2];
      default: vote_res = res[0];
    endcase

    // Two survivors: agreement confirms both, disagreement is unattributable.
    if (two_act) begin
      vote_res = res[lo];
      if (res[lo] == res[hi]) begin
        vote_chk[lo] = 1'b1;
        vote_chk[hi] = 1'b1;
      end else begin
        vote_unc = 1'b1;
      end
    end
  end

  // Per-replica health FSMs and counters; clear_i overrides any vote update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the per-replica state arrays are tiny control registers, not a
      // RAM, so they are reset explicitly like any other flop.
      for (int i = 0; i < 3; i++) begin
        state_q[i]   <= HEALTHY;
        run_cnt_q[i] <= '0;
        err_cnt_q[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i]   <= HEALTHY;
        run_cnt_q[i] <= '0;
        err_cnt_q[i] <= '0;
      end
    end else if (valid_i) begin
      for (int i = 0; i < 3; i++) begin
        if (vote_chk[i]) begin
          if (vote_mis[i]) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values regardless of statement order.
            err_cnt_q[i] <= err_inc[i];
            run_cnt_q[i] <= run_inc[i];
            state_q[i]   <= (run_inc[i] >= THRESH_C) ? FAILED : SUSPECT;
          end else begin
            run_cnt_q[i] <= '0;
            state_q[i]   <= HEALTHY;
          end
        end
      end
    end
  end

  // Registered vote outputs; flags pulse for one cycle, result holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o   <= '0;
      valid_o    <= 1'b0;
      mismatch_o <= '0;
      uncorr_o   <= 1'b0;
    end else begin
      valid_o    <= valid_i;
      mismatch_o <= valid_i ? vote_mis : 3'b000;
      uncorr_o   <= valid_i & vote_unc;
      if (valid_i) result_o <= vote_res;
    end
  end

endmodule

// File: tb/tb_cv32e40p_voter_monitor.sv
// Self-checking bench for cv32e40p_voter_monitor: directed test-plan vectors
// plus randomized triples compared every cycle against a behavioural model.
// Build with +define+VOTER_BITWISE_EN to exercise the per-bit majority vote.

module tb_cv32e40p_voter_monitor;

  localparam int WIDTH  = 32;
  localparam int CNT_W  = 8;
  localparam int THRESH = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               valid = 1'b0;
  logic               clear = 1'b0;
  logic [WIDTH-1:0]   r1 = '0, r2 = '0, r3 = '0;
  logic [WIDTH-1:0]   result;
  logic               valid_out;
  logic [2:0]         mismatch;
  logic               uncorr;
  logic [2:0]         failed;
  logic               fatal;
  logic [3*CNT_W-1:0] err_cnt;

  cv32e40p_voter_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .res1_i    (r1),
    .res2_i    (r2),
    .res3_i    (r3),
    .clear_i   (clear),
    .result_o  (result),
    .valid_o   (valid_out),
    .mismatch_o(mismatch),
    .uncorr_o  (uncorr),
    .failed_o  (failed),
    .fatal_o   (fatal),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: failure flag, consecutive-miss run and total count.
  bit mfail [3];
  int mrun  [3];
  int merr  [3];

  // Pending (computed before the edge) and current expected outputs.
  logic [WIDTH-1:0] p_res = '0, e_res = '0;
  logic             p_valid = 0, e_valid = 0;
  logic [2:0]       p_mis = 0, e_mis = 0;
  logic             p_unc = 0, e_unc = 0;
  logic [2:0]       e_failed = 0;
  logic             e_fatal = 0;
  logic [3*CNT_W-1:0] e_err = '0;
  bit               chk_en = 0;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mfail[i] = 0;
      mrun[i]  = 0;
      merr[i]  = 0;
    end
  endfunction

  function automatic void model_publish();
    int nf;
    nf = 0;
    for (int i = 0; i < 3; i++) begin
      e_failed[i] = mfail[i];
      e_err[i*CNT_W +: CNT_W] = CNT_W'(merr[i]);
      nf += int'(mfail[i]);
    end
    e_fatal = (nf >= 2);
  endfunction

  task automatic model_step(input logic v, input logic c,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r [3];
    logic [WIDTH-1:0] res;
    int               act [$];
    bit [2:0]         mis, chk;
    bit               unc;
    int               maj, cnt, ones;
    r[0] = a; r[1] = b; r[2] = d;
    res = r[0]; mis = 0; chk = 0; unc = 0; maj = -1;
    for (int i = 0; i < 3; i++) if (!mfail[i]) act.push_back(i);
    if (act.size() == 3) begin
`ifdef VOTER_BITWISE_EN
      for (int k = 0; k < WIDTH; k++) begin
        ones = int'(r[0][k]) + int'(r[1][k]) + int'(r[2][k]);
        res[k] = (ones >= 2);
      end
      chk = 3'b111;
      for (int i = 0; i < 3; i++) mis[i] = (r[i] != res);
`else
      for (int i = 0; i < 3; i++) begin
        cnt = 0;
        for (int j = 0; j < 3; j++) if (r[j] == r[i]) cnt++;
        if (cnt >= 2 && maj < 0) maj = i;
      end
      if (maj < 0) begin
        res = r[1];
        unc = 1;
      end else begin
        res = r[maj];
        chk = 3'b111;
        for (int i = 0; i < 3; i++) mis[i] = (r[i] != res);
      end
`endif
    end else if (act.size() == 2) begin
      res = r[act[0]];
      if (r[act[0]] == r[act[1]]) begin
        chk[act[0]] = 1;
        chk[act[1]] = 1;
      end else begin
        unc = 1;
      end
    end else if (act.size() == 1) begin
      res = r[act[0]];
    end
    if (c) model_reset();
    else if (v) begin
      for (int i = 0; i < 3; i++) begin
        if (chk[i]) begin
          if (mis[i]) begin
            if (merr[i] < SAT) merr[i]++;
            mrun[i]++;
            if (mrun[i] >= THRESH) mfail[i] = 1;
          end else begin
            mrun[i] = 0;
          end
        end
      end
    end
    p_valid = v;
    p_mis   = v ? mis : 3'b000;
    p_unc   = v & unc;
    if (v) p_res = res;
  endtask

  // Drive one cycle; returns 1 time unit after the edge that took it.
  task automatic step(input logic v, input logic c, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] d);
    valid = v; clear = c; r1 = a; r2 = b; r3 = d;
    model_step(v, c, a, b, d);
    @(posedge clk);
    #1;
    e_res = p_res; e_valid = p_valid; e_mis = p_mis; e_unc = p_unc;
    model_publish();
  endtask

  task automatic do_reset();
    rst = 1; valid = 0; clear = 0;
    model_reset();
    p_res = '0; p_valid = 0; p_mis = 0; p_unc = 0;
    e_res = '0; e_valid = 0; e_mis = 0; e_unc = 0;
    model_publish();
    chk_en = 1;
    #1;
    check("rst_async_valid", valid_out, 1'b0);
    check("rst_async_result", result, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_failed", failed, 3'b000);
    check("rst_err", err_cnt, '0);
    check("rst_fatal", fatal, 1'b0);
    rst = 0;
  endtask

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("result_o", result, e_res);
      check("valid_o", valid_out, e_valid);
      check("mismatch_o", mismatch, e_mis);
      check("uncorr_o", uncorr, e_unc);
      check("failed_o", failed, e_failed);
      check("fatal_o", fatal, e_fatal);
      check("err_cnt_o", err_cnt, e_err);
    end
  end

  initial begin
    logic [WIDTH-1:0] base, a, b, d;
    logic             v, c;
    #2;
    do_reset();

    // All agree.
    step(1, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    check("agree_result", result, 32'hA5A5_A5A5);
    check("agree_valid", valid_out, 1'b1);
    check("agree_mis", mismatch, 3'b000);
    check("agree_err", err_cnt, '0);

    // Replica 3 fails after THRESH consecutive misses.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 32'h1, 32'h1, 32'h2);
      check("r3_result", result, 32'h1);
      check("r3_mis", mismatch, 3'b100);
    end
    check("r3_failed", failed, 3'b100);
    check("r3_err", err_cnt[23:16], 8'd4);

    // Two survivors disagree: lower index wins, unresolved.
    step(1, 0, 32'h7, 32'h8, 32'h8);
    check("two_result", result, 32'h7);
    check("two_unc", uncorr, 1'b1);
    check("two_failed", failed, 3'b100);

    // Clear without a vote: result holds.
    step(0, 1, 32'h0, 32'h0, 32'h0);
    check("clr_failed", failed, 3'b000);
    check("clr_err", err_cnt, '0);
    check("clr_hold", result, 32'h7);

    // Agreeing vote breaks the run on replica 2.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h5, 32'h9, 32'h5);
    step(1, 0, 32'h5, 32'h5, 32'h5);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h5, 32'h9, 32'h5);
    check("r2_failed", failed, 3'b000);
    check("r2_err", err_cnt[15:8], 8'd6);

    // clear_i beats a mismatch that would otherwise fail replica 1.
    step(1, 1, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h3, 32'h4, 32'h4);
    step(1, 1, 32'h3, 32'h4, 32'h4);
    check("clrpri_mis", mismatch, 3'b001);
    check("clrpri_failed", failed, 3'b000);
    check("clrpri_err", err_cnt, '0);

`ifdef VOTER_BITWISE_EN
    step(1, 0, 32'h3, 32'h5, 32'h6);
    check("bw_result", result, 32'h7);
    check("bw_mis", mismatch, 3'b111);
    check("bw_unc", uncorr, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h3, 32'h5, 32'h6);
    check("bw_fatal", fatal, 1'b1);
    check("bw_failed", failed, 3'b111);
    step(1, 1, 32'h0, 32'h0, 32'h0);
`else
    step(1, 0, 32'h0, 32'h1, 32'h2);
    check("wd_result", result, 32'h1);
    check("wd_unc", uncorr, 1'b1);
    check("wd_mis", mismatch, 3'b000);
    check("wd_err", err_cnt, '0);
`endif

    // Total counter saturates while the run keeps being broken.
    for (int i = 0; i < 130; i++) begin
      step(1, 0, 32'h9, 32'h5, 32'h5);
      step(1, 0, 32'h9, 32'h5, 32'h5);
      step(1, 0, 32'h5, 32'h5, 32'h5);
    end
    check("sat_err", err_cnt[7:0], 8'hFF);
    check("sat_failed", failed, 3'b000);

    // Reset mid-operation drops the pending vote at once.
    step(1, 0, 32'h1234, 32'h1234, 32'h1234);
    do_reset();

    // Randomized triples with occasional clears and resets.
    for (int n = 0; n < 3000; n++) begin
      base = $urandom;
      a = base; b = base; d = base;
      if ($urandom_range(0, 4) == 0) a = WIDTH'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) b = WIDTH'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) d = WIDTH'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(v, c, a, b, d);
    end

    step(0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
